mem_access: RTL
===============

# mem_access

Load/store access unit between the CPU memory stage and the `ram` block. It accepts one word or byte request at a time and drives the RAM's address, data and write-enable lines, working with the RAM's one-cycle synchronous read. It returns load data and status through a single-cycle response pulse. Byte stores are done as a read-modify-write, because the RAM only writes whole words.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of the attached RAM; must equal the RAM's ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nreset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; a request is accepted on an edge where req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  `FULLW  byte address.
- req_wdata  in  `FULLW  store data; byte stores use bits [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  `FULLW  load result; holds its value until the next load completes.
- resp_err  out  1  qualified by resp_valid; the access was rejected.
- ram_ad  out  `FULLW  RAM address.
- ram_d  out  `FULLW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_q  in  `FULLW  RAM read data (registered inside the RAM).

## Operation
- Byte order is big-endian. Byte offset k = req_addr[1:0] maps to word bits [(3-k)*8 +: 8].
- Request registers: on acceptance the unit latches req_we, req_byte, req_addr and req_wdata.
- Error conditions:
  - word access with req_addr[1:0] != 0;
  - any access with req_addr[31:ADDR_WIDTH] != 0.
  - On error there is no RAM write, resp_err=1, and resp_rdata is unchanged.
- FSM states: IDLE, LD_WAIT, RMW_WR.
- IDLE:
  - req_ready=1.
  - ram_ad is driven combinationally as {req_addr[31:2],2'b00}.
  - ram_we = req_valid && req_we && !req_byte && !err.
  - ram_d = req_wdata.
- IDLE transitions on acceptance:
  - error, or word store: stay in IDLE; resp_valid on the next cycle.
  - load (word or byte): go to LD_WAIT.
  - byte store: go to RMW_WR.
- LD_WAIT:
  - req_ready=0; ram_ad is held from the latched address.
  - On the edge, resp_rdata is captured. Word load: ram_q. Byte load: the selected byte, zero-extended.
  - resp_valid=1 in the following cycle; go to IDLE.
- RMW_WR:
  - req_ready=0; ram_ad is held.
  - ram_d = ram_q with byte lane k replaced by the latched wdata[7:0]; ram_we=1.
  - On the edge the merged word is written; resp_valid in the following cycle; go to IDLE.
- ram_we is forced to 0 while nreset=0.

## Timing
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0. req_ready goes to 1 as soon as reset is released.
- Latency is measured from the acceptance edge to the cycle in which resp_valid=1:
  - word store or error: 1 cycle;
  - load: 2 cycles;
  - byte store: 2 cycles.
- Back-to-back: a new request may be accepted in the same cycle that resp_valid is high. Word stores sustain 1 per cycle.
- There is no back-pressure on the response; the consumer must take it in that cycle.
- Reset asserted in LD_WAIT or RMW_WR aborts the access: no write occurs, no response is produced, and memory keeps its old contents.
- A store immediately followed by a load to the same word returns the stored data. The write completes on the store's own edge, before the load's read edge.

## Structure
- Add to defines.v:
  - state encodings `MA_IDLE, `MA_LD_WAIT, `MA_RMW_WR;
  - `BYTEOFF_W = 2.
- Reuse the existing `FULLW, `WIDTH and `WORD.
- Sub-module `byte_lane` (combinational) handles extract (word, offset → zero-extended byte) and merge (word, byte, offset → word). It is shared by the load and RMW paths.
- Expected size: 150–250 lines of RTL.

## Test plan
- Word store then word load: store 0x11223344 at 0x10, then load 0x10. Store response 1 cycle after acceptance; load returns 0x11223344 with resp_valid 2 cycles after acceptance.
- Byte load: memory at 0x20 holds 0xAABBCCDD; load byte from 0x22. resp_rdata=0x000000CC.
- Byte store: memory at 0x20 holds 0xAABBCCDD; store byte 0x5A to 0x21. During RMW_WR, req_ready=0 and ram_we=1; the following word load at 0x20 returns 0xAA5ACCDD.
- Errors:
  - word load at 0x13 gives resp_err=1 after 1 cycle, resp_rdata unchanged, ram_we never 1;
  - word store at 0x100 (ADDR_WIDTH=8) gives resp_err=1 with no write.
- Reset abort: assert nreset=0 while in RMW_WR. Memory is unchanged, no resp_valid appears, and all outputs are at their reset values immediately.
- Back-to-back: four word stores on consecutive cycles to 0x0, 0x4, 0x8, 0xC. Four consecutive resp_valid pulses; read-back matches all four.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared widths, FSM encodings and request-legality helper for the load/store access unit.
package mem_access_pkg;

  localparam int FULLW     = 32;
  localparam int WIDTH     = 8;
  localparam int BYTEOFF_W = 2;

  localparam logic [1:0] MA_IDLE    = 2'd0;
  localparam logic [1:0] MA_LD_WAIT = 2'd1;
  localparam logic [1:0] MA_RMW_WR  = 2'd2;

  // Misaligned word access, or any address bit above the RAM's range, is rejected.
  function automatic logic access_err(input logic [FULLW-1:0] addr,
                                      input logic             is_byte,
                                      input int               aw);
    access_err = (!is_byte && (addr[BYTEOFF_W-1:0] != '0)) || ((addr >> aw) != '0);
  endfunction

endpackage

// File: rtl/mem_access_byte_lane.sv
// Big-endian byte lane helper: extracts one byte (zero-extended) and merges one byte into a word.
module mem_access_byte_lane
  import mem_access_pkg::*;
(
  input  logic [FULLW-1:0]     i_word,
  input  logic [WIDTH-1:0]     i_byte,
  input  logic [BYTEOFF_W-1:0] i_off,
  output logic [FULLW-1:0]     o_extract,
  output logic [FULLW-1:0]     o_merge
);

  localparam int LANES = FULLW / WIDTH;

  logic [WIDTH-1:0] w_lane [LANES];

  // Offset 0 is the most significant byte of the word.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = i_word[(LANES-1-gi)*WIDTH +: WIDTH];
      assign o_merge[(LANES-1-gi)*WIDTH +: WIDTH] =
        (i_off == BYTEOFF_W'(gi)) ? i_byte : w_lane[gi];
    end
  endgenerate

  assign o_extract = {{(FULLW-WIDTH){1'b0}}, w_lane[i_off]};

endmodule

// File: rtl/mem_access.sv
// Load/store unit in front of a word-wide RAM with one-cycle registered read;
// byte stores go through a read-modify-write of the containing word.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_byte,
  input  logic [FULLW-1:0] req_addr,
  input  logic [FULLW-1:0] req_wdata,
  output logic             resp_valid,
  output logic [FULLW-1:0] resp_rdata,
  output logic             resp_err,
  output logic [FULLW-1:0] ram_ad,
  output logic [FULLW-1:0] ram_d,
  output logic             ram_we,
  input  logic [FULLW-1:0] ram_q
);

  logic [1:0]       r_state;
  logic             r_byte;
  logic [FULLW-1:0] r_addr;
  logic [WIDTH-1:0] r_wbyte;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [FULLW-1:0] r_resp_rdata;

  logic             w_idle;
  logic             w_accept;
  logic             w_err;
  logic [FULLW-1:0] w_extract;
  logic [FULLW-1:0] w_merge;
  logic [FULLW-1:0] w_ram_ad;
  logic [FULLW-1:0] w_ram_d;
  logic             w_ram_we;

  assign w_idle   = (r_state == MA_IDLE);
  assign w_accept = req_valid && w_idle;
  assign w_err    = access_err(req_addr, req_byte, ADDR_WIDTH);

  // One lane instance serves both the byte-load extract and the RMW merge,
  // since both operate on the RAM read word at the latched offset.
  mem_access_byte_lane u_lane (
    .i_word    (ram_q),
    .i_byte    (r_wbyte),
    .i_off     (r_addr[BYTEOFF_W-1:0]),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  always_comb begin
    w_ram_ad = {r_addr[FULLW-1:BYTEOFF_W], {BYTEOFF_W{1'b0}}};
    w_ram_d  = req_wdata;
    w_ram_we = 1'b0;
    case (r_state)
      MA_IDLE: begin
        w_ram_ad = {req_addr[FULLW-1:BYTEOFF_W], {BYTEOFF_W{1'b0}}};
        w_ram_we = req_valid && req_we && !req_byte && !w_err;
      end
      MA_RMW_WR: begin
        w_ram_d  = w_merge;
        w_ram_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= MA_IDLE;
      r_byte       <= 1'b0;
      r_addr       <= '0;
      r_wbyte      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        MA_IDLE: begin
          if (w_accept) begin
            r_byte  <= req_byte;
            r_addr  <= req_addr;
            r_wbyte <= req_wdata[WIDTH-1:0];
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!req_we) begin
              r_state <= MA_LD_WAIT;
            end else if (req_byte) begin
              r_state <= MA_RMW_WR;
            end else begin
              r_resp_valid <= 1'b1;
            end
          end
        end
        MA_LD_WAIT: begin
          r_resp_rdata <= r_byte ? w_extract : ram_q;
          r_resp_valid <= 1'b1;
          r_state      <= MA_IDLE;
        end
        MA_RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= MA_IDLE;
        end
        default: r_state <= MA_IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign ram_ad     = w_ram_ad;
  assign ram_d      = w_ram_d;
  // Gate with reset so an access aborted mid-RMW can never write.
  assign ram_we     = w_ram_we && nreset;

endmodule
